// File: rtl/pov_frame_player.sv
// Angle-indexed LED pattern player for a rotating POV fan. It tracks blade angle from
// fanclk/index and plays multi-frame patterns stored in an internal writable RAM.
module pov_frame_player #(
  parameter int unsigned NUM_LEDS       = 16,
  parameter int unsigned STEPS          = 360,
  parameter int unsigned NUM_FRAMES     = 4,
  parameter int unsigned REVS_PER_FRAME = 8,
  localparam int unsigned AW = $clog2(STEPS),
  localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fanclk,
  input  logic                index,
  input  logic                dir,
  input  logic                en,
  input  logic                loop,
  input  logic                wr_en,
  input  logic [FW-1:0]       wr_frame,
  input  logic [AW-1:0]       wr_step,
  input  logic [NUM_LEDS-1:0] wr_data,
  output logic [NUM_LEDS-1:0] led,
  output logic [AW-1:0]       angle,
  output logic [FW-1:0]       frame,
  output logic                rev_tick
);

  localparam int unsigned DEPTH = NUM_FRAMES * STEPS;
  localparam int unsigned DW    = $clog2(DEPTH);

  localparam logic [AW-1:0] LAST_STEP  = AW'(STEPS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
  localparam logic [7:0]    RPF        = 8'(REVS_PER_FRAME);

  // Bits [1:0] synchronise, bit [2] holds the previous synchronised value.
  logic [2:0] fan_sr, idx_sr;
  logic       fan_edge, idx_edge;

  logic [7:0]    rev_cnt, rev_cnt_d;
  logic [AW-1:0] angle_d;
  logic [FW-1:0] frame_d;
  logic          rev;

  logic [DW-1:0] rd_addr, wr_addr;
  logic          wr_ok;

  logic                wr_vld_q;
  logic [DW-1:0]       wr_addr_q;
  logic [NUM_LEDS-1:0] wr_data_q;

  logic [NUM_LEDS-1:0] mem [DEPTH];

  assign fan_edge = fan_sr[1] & ~fan_sr[2];
  assign idx_edge = idx_sr[1] & ~idx_sr[2];

  // Index takes priority over a coincident step; either way at most one revolution.
  always_comb begin
    angle_d = angle;
    rev     = 1'b0;
    if (idx_edge) begin
      angle_d = '0;
      rev     = 1'b1;
    end else if (fan_edge) begin
      if (dir) begin
        if (angle == LAST_STEP) begin
          angle_d = '0;
          rev     = 1'b1;
        end else begin
          angle_d = angle + 1'b1;
        end
      end else begin
        if (angle == '0) begin
          angle_d = LAST_STEP;
          rev     = 1'b1;
        end else begin
          angle_d = angle - 1'b1;
        end
      end
    end
  end

  always_comb begin
    rev_cnt_d = rev_cnt;
    frame_d   = frame;
    if (rev) begin
      if (rev_cnt + 8'd1 == RPF) begin
        rev_cnt_d = '0;
        if (NUM_FRAMES == 1) begin
          frame_d = '0;
        end else if (frame == LAST_FRAME) begin
          frame_d = loop ? '0 : LAST_FRAME;
        end else begin
          frame_d = frame + 1'b1;
        end
      end else begin
        rev_cnt_d = rev_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    rd_addr = DW'(32'(frame) * STEPS + 32'(angle));
    wr_addr = DW'(32'(wr_frame) * STEPS + 32'(wr_step));
    wr_ok   = wr_en && (32'(wr_step) < STEPS) && (32'(wr_frame) < NUM_FRAMES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fan_sr   <= '0;
      idx_sr   <= '0;
      angle    <= '0;
      frame    <= '0;
      rev_cnt  <= '0;
      rev_tick <= 1'b0;
      led      <= '0;
    end else begin
      fan_sr   <= {fan_sr[1:0], fanclk};
      idx_sr   <= {idx_sr[1:0], index};
      angle    <= angle_d;
      frame    <= frame_d;
      rev_cnt  <= rev_cnt_d;
      rev_tick <= rev;
      led      <= en ? mem[rd_addr] : '0;
    end
  end

  // Write request is staged one cycle so the RAM read port sees old data first.
  always_ff @(posedge clk) begin
    wr_vld_q  <= wr_ok;
    wr_addr_q <= wr_addr;
    wr_data_q <= wr_data;
    if (wr_vld_q) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

endmodule
